rob_multiport: RTL
==================

ROB_MULTIPORT -- requirements
Module: rob_multiport

Interface
REQ-001 SHALL have parameter REGISTER_SIZE, default 32, data width per entry.
REQ-002 SHALL have parameter REG_ADDRESS_SIZE, default 5, destination register address width.
REQ-003 SHALL have parameter ID_SIZE, default 3, entry id width; depth = 2^ID_SIZE.
REQ-004 SHALL have parameter NPORTS, default 2, number of write-back ports (1..4).
REQ-005 SHALL have ports:
- clk  in  1  sole clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- alloc_req  in  1  request a new entry at tail.
- alloc_id  out  ID_SIZE  id granted this cycle (tail index).
- alloc_stall  out  1  ROB full, allocation refused.
- port_req  in  NPORTS  per-port write-back request.
- port_id  in  NPORTS*ID_SIZE  packed target ids, port i at bits [i*ID_SIZE +: ID_SIZE].
- port_address  in  NPORTS*REG_ADDRESS_SIZE  packed destination addresses.
- port_data  in  NPORTS*REGISTER_SIZE  packed result data.
- port_w  in  NPORTS  packed register-write enables.
- port_stall  out  NPORTS  port write refused this cycle.
- flush  in  1  discard all entries.
- current_address  out  REG_ADDRESS_SIZE  head entry address.
- current_data  out  REGISTER_SIZE  head entry data.
- current_write  out  1  head commits this cycle with register write.
- commit_valid  out  1  head commits this cycle.
- count  out  ID_SIZE+1  occupied entries.
- lookup_address  in  REG_ADDRESS_SIZE  forwarding query (ROB_LOOKUP_EN only).
- lookup_hit  out  1  forwarding match found.
- lookup_data  out  REGISTER_SIZE  forwarded data.

Function
REQ-006 SHALL keep head and tail pointers of ID_SIZE+1 bits; empty = pointers equal; full = low bits equal, MSBs differ; count = tail-head modulo 2^(ID_SIZE+1).
REQ-007 SHALL drive alloc_id = tail low bits and alloc_stall = full combinationally.
REQ-008 SHALL, on alloc_req && !full && !flush, mark entry allocated and not done, and increment tail at the next edge.
REQ-009 SHALL, on port_req[i] to an allocated, not-done id, store data, address, w and set done at the next edge.
REQ-010 SHALL allow all NPORTS ports to write in the same cycle when ids differ.
REQ-011 SHALL, when ports collide on one id, accept the lowest-index port and assert port_stall on all others that cycle.
REQ-012 SHALL silently ignore writes to unallocated or already-done entries; port_stall stays 0.
REQ-013 SHALL assert commit_valid combinationally when head entry is allocated and done; current_write = commit_valid && head w.
REQ-014 SHALL, when commit_valid, clear the head entry and increment head at the next edge; at most one commit per cycle.
REQ-015 SHALL evaluate alloc_stall from registered pointers: a commit in a full cycle frees space only from the next cycle.
REQ-016 SHALL allow allocation and commit in the same cycle; count unchanged.
REQ-017 SHALL wrap pointers modulo 2^(ID_SIZE+1) with no special handling.
REQ-018 SHALL, on flush, clear all allocated/done flags and set head = tail = 0 at the next edge; flush overrides alloc, write-back and commit, and suppresses commit_valid that cycle.

Reset
REQ-019 SHALL, when reset = 0 at a rising edge, set head = tail = 0 and clear all allocated/done flags; entry data/address are not cleared.
REQ-020 SHALL give after reset: commit_valid = 0, current_write = 0, alloc_stall = 0, count = 0, alloc_id = 0, port_stall = 0, lookup_hit = 0.
REQ-021 SHALL give reset priority over flush and all other inputs, including mid-operation with entries pending.

Configuration
REQ-022 SHALL compile the forwarding lookup only when macro ROB_LOOKUP_EN is defined: lookup_hit = 1 and lookup_data = data of the youngest allocated, done entry with w = 1 and matching address; otherwise lookup_hit = 0, lookup_data = 0.
REQ-023 SHALL, without ROB_LOOKUP_EN, tie lookup_hit and lookup_data to 0 and ignore lookup_address.

Verification (ID_SIZE=2, NPORTS=2, REGISTER_SIZE=32)
REQ-024 Reset low one edge, then 4 alloc_req cycles -> alloc_id 0,1,2,3; count 4; 5th alloc_req sees alloc_stall = 1, tail unchanged.
REQ-025 Alloc ids 0,1; same cycle port0 id1 data 0xB, port1 id0 data 0xA, w=1, addr 3 and 4 -> next cycle commit_valid with current_data 0xA, addr 3's partner order kept: id0 then id1 (0xB) commits.
REQ-026 Both ports target id 2 same cycle -> port_stall = 2'b10, entry holds port0 data.
REQ-027 Full ROB, head done, alloc_req asserted -> commit this cycle, alloc_stall = 1; next cycle alloc accepted with alloc_id = old head, count returns to 4.
REQ-028 Three entries pending, flush = 1 -> next cycle count 0, commit_valid 0, alloc_id 0.
REQ-029 With ROB_LOOKUP_EN: entries 0 and 1 done, both addr 7, data 0x11 then 0x22 -> lookup_address 7 gives lookup_hit 1, lookup_data 0x22; without macro lookup_hit 0.

Source files
------------

// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: in-order allocate at the tail, out-of-order write-back on NPORTS ports, in-order commit at the head.
// Optional forwarding lookup of the youngest completed result is compiled in with ROB_LOOKUP_EN.
module rob_multiport #(
    parameter int REGISTER_SIZE    = 32,
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int ID_SIZE          = 3,
    parameter int NPORTS           = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               alloc_req,
    output logic [ID_SIZE-1:0]                 alloc_id,
    output logic                               alloc_stall,
    input  logic [NPORTS-1:0]                  port_req,
    input  logic [NPORTS*ID_SIZE-1:0]          port_id,
    input  logic [NPORTS*REG_ADDRESS_SIZE-1:0] port_address,
    input  logic [NPORTS*REGISTER_SIZE-1:0]    port_data,
    input  logic [NPORTS-1:0]                  port_w,
    output logic [NPORTS-1:0]                  port_stall,
    input  logic                               flush,
    output logic [REG_ADDRESS_SIZE-1:0]        current_address,
    output logic [REGISTER_SIZE-1:0]           current_data,
    output logic                               current_write,
    output logic                               commit_valid,
    output logic [ID_SIZE:0]                   count,
    input  logic [REG_ADDRESS_SIZE-1:0]        lookup_address,
    output logic                               lookup_hit,
    output logic [REGISTER_SIZE-1:0]           lookup_data
);
    localparam int DEPTH = 1 << ID_SIZE;

    logic [ID_SIZE:0]              head, tail;
    logic [DEPTH-1:0]              allocated, done, wr;
    logic [REGISTER_SIZE-1:0]      data_q [DEPTH];
    logic [REG_ADDRESS_SIZE-1:0]   addr_q [DEPTH];
    logic [ID_SIZE-1:0]            pid [NPORTS];
    logic [NPORTS-1:0]             port_ok;
    logic [ID_SIZE-1:0]            head_idx, tail_idx;
    logic                          full;

    assign head_idx    = head[ID_SIZE-1:0];
    assign tail_idx    = tail[ID_SIZE-1:0];
    assign full        = (head_idx == tail_idx) && (head[ID_SIZE] != tail[ID_SIZE]);
    assign count       = tail - head;
    assign alloc_id    = tail_idx;
    assign alloc_stall = full;

    assign commit_valid    = !flush && allocated[head_idx] && done[head_idx];
    assign current_write   = commit_valid && wr[head_idx];
    assign current_data    = data_q[head_idx];
    assign current_address = addr_q[head_idx];

    for (genvar g = 0; g < NPORTS; g++) begin : g_pid
        assign pid[g] = port_id[g*ID_SIZE +: ID_SIZE];
    end

    // A port is only stalled when it actually loses a race for a writable entry
    always_comb begin
        port_ok    = '0;
        port_stall = '0;
        for (int i = 0; i < NPORTS; i++) begin
            logic writable, clash;
            writable = port_req[i] && allocated[pid[i]] && !done[pid[i]];
            clash    = 1'b0;
            for (int j = 0; j < i; j++)
                clash = clash | (port_req[j] && (pid[j] == pid[i]));
            port_ok[i]    = writable && !clash;
            port_stall[i] = writable && clash;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            head      <= '0;
            tail      <= '0;
            allocated <= '0;
            done      <= '0;
        end else begin
            // Alloc (tail) and commit (head) never alias: that needs full or empty
            if (alloc_req && !full) begin
                allocated[tail_idx] <= 1'b1;
                done[tail_idx]      <= 1'b0;
                tail                <= tail + 1'b1;
            end
            for (int i = 0; i < NPORTS; i++)
                if (port_ok[i]) done[pid[i]] <= 1'b1;
            if (commit_valid) begin
                allocated[head_idx] <= 1'b0;
                done[head_idx]      <= 1'b0;
                head                <= head + 1'b1;
            end
        end
    end

    // Payload is not reset; it is only meaningful behind the done flag
    always_ff @(posedge clk) begin
        if (reset && !flush) begin
            for (int i = 0; i < NPORTS; i++) begin
                if (port_ok[i]) begin
                    data_q[pid[i]] <= port_data[i*REGISTER_SIZE +: REGISTER_SIZE];
                    addr_q[pid[i]] <= port_address[i*REG_ADDRESS_SIZE +: REG_ADDRESS_SIZE];
                    wr[pid[i]]     <= port_w[i];
                end
            end
        end
    end

`ifdef ROB_LOOKUP_EN
    // Walk oldest to youngest so the last match found is the youngest
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [ID_SIZE-1:0] idx;
            idx = head_idx + k[ID_SIZE-1:0];
            if (allocated[idx] && done[idx] && wr[idx] && (addr_q[idx] == lookup_address)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[idx];
            end
        end
    end
`else
    logic unused_lookup;
    assign unused_lookup = ^lookup_address;
    assign lookup_hit    = 1'b0;
    assign lookup_data   = '0;
`endif

endmodule
